// File: rtl/cal_sequencer.sv
// cal_sequencer
//   Sequences gyro calibration after the command decoder issues a calibrate
//   request. It pulses strt_cal to the inertial integrator, waits for cal_done
//   under a watchdog timeout, and sends an ack byte through the shared UART
//   transmitter using a trmt/tx_done handshake. Sticky pass/fail status is
//   held for the command processor and the piezo driver.
//
//   Optional feature: define CAL_RETRY_EN to give the integrator a second
//   attempt after the first timeout before NEG_ACK is sent.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   cal_req   in   1-cycle calibrate request (ignored while busy)
//   cal_done  in   calibration finished; sampled only while waiting for it
//   tx_done   in   UART byte fully shifted out; honoured only while waiting for it
//   strt_cal  out  1-cycle start pulse to the inertial integrator
//   trmt      out  1-cycle UART transmit strobe
//   tx_data   out  ack byte, stable from trmt until tx_done
//   cal_busy  out  sequence in progress
//   cal_ok    out  sticky: last calibration passed
//   cal_fail  out  sticky: last calibration timed out
module cal_sequencer #(
    parameter int unsigned FAST_SIM    = 0,
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned FAST_TO_CYC = 4096,
    parameter logic [7:0]  POS_ACK     = 8'hA5,
    parameter logic [7:0]  NEG_ACK     = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cal_req,
    input  logic       cal_done,
    input  logic       tx_done,
    output logic       strt_cal,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       cal_busy,
    output logic       cal_ok,
    output logic       cal_fail
);

    localparam int unsigned TO_CYC    = (FAST_SIM != 0) ? FAST_TO_CYC : TIMEOUT_CYC;
    // Timer counts from 0 on the first WAIT_CAL cycle, so the last allowed
    // cycle is the one where it reads TO_CYC-1.
    localparam logic [25:0] TO_LAST   = 26'(TO_CYC - 1);
    localparam logic [25:0] TIMER_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_CAL,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t      state_q;
    logic [25:0] timer_q;
    logic        strt_cal_q;
    logic        trmt_q;
    logic [7:0]  tx_data_q;
    logic        cal_busy_q;
    logic        cal_ok_q;
    logic        cal_fail_q;
`ifdef CAL_RETRY_EN
    logic        retry_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            strt_cal_q <= 1'b0;
            trmt_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            cal_busy_q <= 1'b0;
            cal_ok_q   <= 1'b0;
            cal_fail_q <= 1'b0;
`ifdef CAL_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle: they default low and are raised only
            // on the transition into the state that owns them.
            strt_cal_q <= 1'b0;
            trmt_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cal_req) begin
                        state_q    <= S_START;
                        strt_cal_q <= 1'b1;
                        cal_busy_q <= 1'b1;
                        cal_ok_q   <= 1'b0;
                        cal_fail_q <= 1'b0;
`ifdef CAL_RETRY_EN
                        retry_q    <= 1'b0;
`endif
                    end
                end

                S_START: begin
                    timer_q <= '0;
                    state_q <= S_WAIT_CAL;
                end

                S_WAIT_CAL: begin
                    // Saturate rather than wrap so a stuck FSM can never
                    // re-arm the timeout by rolling over.
                    if (timer_q != TIMER_MAX) begin
                        timer_q <= timer_q + 26'd1;
                    end

                    // cal_done takes priority over a simultaneous timeout.
                    if (cal_done) begin
                        tx_data_q <= POS_ACK;
                        trmt_q    <= 1'b1;
                        state_q   <= S_SEND;
                    end else if (timer_q == TO_LAST) begin
`ifdef CAL_RETRY_EN
                        if (!retry_q) begin
                            retry_q    <= 1'b1;
                            strt_cal_q <= 1'b1;
                            state_q    <= S_START;
                        end else begin
                            tx_data_q <= NEG_ACK;
                            trmt_q    <= 1'b1;
                            state_q   <= S_SEND;
                        end
`else
                        tx_data_q <= NEG_ACK;
                        trmt_q    <= 1'b1;
                        state_q   <= S_SEND;
`endif
                    end
                end

                S_SEND: begin
                    // trmt is high during this state; tx_done cannot be
                    // legitimately returned yet, so it is not looked at.
                    state_q <= S_WAIT_TX;
                end

                S_WAIT_TX: begin
                    if (tx_done) begin
                        state_q    <= S_IDLE;
                        cal_busy_q <= 1'b0;
                        if (tx_data_q == POS_ACK) begin
                            cal_ok_q <= 1'b1;
                        end else begin
                            cal_fail_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign strt_cal = strt_cal_q;
    assign trmt     = trmt_q;
    assign tx_data  = tx_data_q;
    assign cal_busy = cal_busy_q;
    assign cal_ok   = cal_ok_q;
    assign cal_fail = cal_fail_q;

endmodule

// File: tb/tb_cal_sequencer.sv
// tb_cal_sequencer
//   Directed bench for cal_sequencer built with FAST_SIM=1, FAST_TO_CYC=4096.
//   Expected ack bytes are queued when a request is driven and checked by a
//   monitor whenever the DUT strobes trmt; an unexpected strobe is an error.
module tb_cal_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cal_req = 1'b0;
    logic       cal_done = 1'b0;
    logic       tx_done = 1'b0;
    logic       strt_cal;
    logic       trmt;
    logic [7:0] tx_data;
    logic       cal_busy;
    logic       cal_ok;
    logic       cal_fail;

    int tests = 0;
    int fails = 0;
    int n_strt = 0;
    int n_trmt = 0;
    logic [7:0] exp_q[$];

    cal_sequencer #(
        .FAST_SIM   (1),
        .FAST_TO_CYC(4096),
        .POS_ACK    (8'hA5),
        .NEG_ACK    (8'h5A)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cal_req (cal_req),
        .cal_done(cal_done),
        .tx_done (tx_done),
        .strt_cal(strt_cal),
        .trmt    (trmt),
        .tx_data (tx_data),
        .cal_busy(cal_busy),
        .cal_ok  (cal_ok),
        .cal_fail(cal_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs driven and outputs read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trmt(input int budget, output int n);
        n = 0;
        while (trmt !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (trmt !== 1'b1) check("trmt_wait_expired", 32'd0, 32'd1);
    endtask

    // Scoreboard side: every trmt strobe must match the oldest queued byte.
    always @(negedge clk) begin
        if (strt_cal === 1'b1) n_strt++;
        if (trmt === 1'b1) begin
            n_trmt++;
            if (exp_q.size() == 0) begin
                check("unexpected_trmt", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("ack_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int s0;
        int t0;
        int n;

        // ---------------- reset state
        step();
        step();
        check("rst_strt_cal", {31'd0, strt_cal}, 32'd0);
        check("rst_trmt",     {31'd0, trmt},     32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_cal_busy", {31'd0, cal_busy}, 32'd0);
        check("rst_cal_ok",   {31'd0, cal_ok},   32'd0);
        check("rst_cal_fail", {31'd0, cal_fail}, 32'd0);
        rst = 1'b0;
        step();

        // ---------------- 1: normal pass, tx_done outside WAIT_TX ignored
        s0 = n_strt;
        exp_q.push_back(8'hA5);
        cal_req = 1'b1;
        step();                                   // cycle 1
        cal_req = 1'b0;
        check("t1_strt_cycle1", {31'd0, strt_cal}, 32'd1);
        check("t1_busy_cycle1", {31'd0, cal_busy}, 32'd1);
        step();                                   // cycle 2
        check("t1_strt_single", {31'd0, strt_cal}, 32'd0);
        tx_done = 1'b1;                           // stray, in WAIT_CAL
        step();
        tx_done = 1'b0;
        for (int c = 3; c < 101; c++) step();     // now cycle 101
        cal_done = 1'b1;
        step();                                   // cycle 102
        cal_done = 1'b0;
        check("t1_trmt_latency", {31'd0, trmt}, 32'd1);
        check("t1_tx_data", {24'd0, tx_data}, 32'hA5);
        for (int c = 0; c < 50; c++) step();
        check("t1_hold_tx_data", {24'd0, tx_data}, 32'hA5);
        check("t1_busy_before_done", {31'd0, cal_busy}, 32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("t1_busy_cleared", {31'd0, cal_busy}, 32'd0);
        check("t1_cal_ok", {31'd0, cal_ok}, 32'd1);
        check("t1_cal_fail", {31'd0, cal_fail}, 32'd0);
        check("t1_strt_count", n_strt - s0, 32'd1);

        // ---------------- 2: timeout path
        step();
        s0 = n_strt;
        exp_q.push_back(8'h5A);
        cal_req = 1'b1;
        step();                                   // cycle 1
        cal_req = 1'b0;
        step();                                   // cycle 2, timer 0
        wait_trmt(9000, n);
`ifdef CAL_RETRY_EN
        check("t2_timeout_cycles", n, 32'd8193);
        check("t2_strt_count", n_strt - s0, 32'd2);
`else
        check("t2_timeout_cycles", n, 32'd4096);
        check("t2_strt_count", n_strt - s0, 32'd1);
`endif
        check("t2_tx_data", {24'd0, tx_data}, 32'h5A);
        tx_done = 1'b1;                           // during SEND: ignored
        step();
        tx_done = 1'b0;
        check("t2_tx_done_in_send_ignored", {31'd0, cal_busy}, 32'd1);
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("t2_cal_fail", {31'd0, cal_fail}, 32'd1);
        check("t2_cal_ok", {31'd0, cal_ok}, 32'd0);
        check("t2_busy_cleared", {31'd0, cal_busy}, 32'd0);

        // ---------------- 3: repeated requests while busy are dropped
        step();
        s0 = n_strt;
        t0 = n_trmt;
        exp_q.push_back(8'hA5);
        cal_req = 1'b1;
        step();                                   // cycle 1
        for (int c = 1; c <= 600; c++) begin
            cal_req  = (c == 10 || c == 500);
            cal_done = (c == 600);
            step();
        end
        cal_req  = 1'b0;
        cal_done = 1'b0;
        check("t3_trmt", {31'd0, trmt}, 32'd1);
        step();
        step();
        tx_done = 1'b1;                           // exit WAIT_TX ...
        cal_req = 1'b1;                           // ... with a request: dropped
        step();
        tx_done = 1'b0;
        cal_req = 1'b0;
        check("t3_busy_cleared", {31'd0, cal_busy}, 32'd0);
        check("t3_cal_ok", {31'd0, cal_ok}, 32'd1);
        step();
        step();
        check("t3_no_restart_busy", {31'd0, cal_busy}, 32'd0);
        check("t3_strt_count", n_strt - s0, 32'd1);
        check("t3_trmt_count", n_trmt - t0, 32'd1);

        // ---------------- 4: cal_done on the last timer cycle wins
        exp_q.push_back(8'hA5);
        cal_req = 1'b1;
        step();                                   // cycle 1
        cal_req = 1'b0;
        for (int c = 1; c < 4097; c++) step();    // now cycle 4097, timer 4095
        check("t4_no_early_trmt", {31'd0, trmt}, 32'd0);
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        check("t4_trmt", {31'd0, trmt}, 32'd1);
        check("t4_tx_data", {24'd0, tx_data}, 32'hA5);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("t4_cal_ok", {31'd0, cal_ok}, 32'd1);
        check("t4_cal_fail", {31'd0, cal_fail}, 32'd0);

        // ---------------- 5: reset in WAIT_TX, then a clean run
        step();
        exp_q.push_back(8'hA5);
        cal_req = 1'b1;
        step();                                   // cycle 1
        cal_req = 1'b0;
        for (int c = 1; c < 5; c++) step();       // cycle 5
        cal_done = 1'b1;
        step();                                   // cycle 6, trmt
        cal_done = 1'b0;
        step();
        step();                                   // WAIT_TX
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_strt_cal", {31'd0, strt_cal}, 32'd0);
        check("t5_trmt",     {31'd0, trmt},     32'd0);
        check("t5_tx_data",  {24'd0, tx_data},  32'd0);
        check("t5_cal_busy", {31'd0, cal_busy}, 32'd0);
        check("t5_cal_ok",   {31'd0, cal_ok},   32'd0);
        check("t5_cal_fail", {31'd0, cal_fail}, 32'd0);
        t0 = n_trmt;
        for (int c = 0; c < 5; c++) step();
        check("t5_no_pending_trmt", n_trmt - t0, 32'd0);
        exp_q.push_back(8'hA5);
        cal_req = 1'b1;
        step();
        cal_req = 1'b0;
        step();
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        check("t5_fresh_trmt", {31'd0, trmt}, 32'd1);
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("t5_fresh_cal_ok", {31'd0, cal_ok}, 32'd1);

        // ---------------- 6: cal_done level held from IDLE
        cal_done = 1'b1;
        step();
        step();
        step();
        check("t6_idle_no_trmt", {31'd0, trmt}, 32'd0);
        exp_q.push_back(8'hA5);
        cal_req = 1'b1;
        step();                                   // cycle 1, START
        cal_req = 1'b0;
        check("t6_start_no_trmt", {31'd0, trmt}, 32'd0);
        check("t6_ok_cleared", {31'd0, cal_ok}, 32'd0);
        step();                                   // cycle 2, WAIT_CAL
        check("t6_waitcal_no_trmt", {31'd0, trmt}, 32'd0);
        step();                                   // cycle 3
        cal_done = 1'b0;
        check("t6_trmt_waitcal_plus1", {31'd0, trmt}, 32'd1);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("t6_cal_ok", {31'd0, cal_ok}, 32'd1);

        step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
